// File: rtl/core_ctrl.sv
// core_ctrl: sequences weight/activation loads, execution, psum drain and output accumulation for one convolution
// Latency: inst, busy and done are registered, one cycle behind the FSM state that produces them
// Backpressure: the drain phase stalls indefinitely while ofifo_valid is low; start is ignored unless idle

module core_ctrl #(
  parameter int col      = 8,
  parameter int len_kij  = 9,
  parameter int len_nij  = 36,
  parameter int len_onij = 16,
  parameter int iw       = 6,
  parameter int ow       = 4,
  parameter int w_base   = 36
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        busy,
  output logic        done
);

  localparam int AW = 11;
  localparam int KW = 3;  // kernel is square, KW x KW = len_kij

  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [AW-1:0] COL_A   = AW'(col);
  localparam logic [AW-1:0] NIJ_A   = AW'(len_nij);
  localparam logic [AW-1:0] NIJ_M1  = AW'(len_nij - 1);
  localparam logic [AW-1:0] KIJ_M1  = AW'(len_kij - 1);
  localparam logic [AW-1:0] KW_M1   = AW'(KW - 1);
  localparam logic [AW-1:0] OW_M1   = AW'(ow - 1);
  localparam logic [AW-1:0] IW_A    = AW'(iw);
  localparam logic [AW-1:0] WB_A    = AW'(w_base);
  localparam logic [AW-1:0] NACC_A  = AW'(len_onij * len_kij);

  typedef struct packed {
    logic          acc;
    logic          cen_pmem;
    logic          wen_pmem;
    logic [AW-1:0] a_pmem;
    logic          cen_xmem;
    logic          wen_xmem;
    logic [AW-1:0] a_xmem;
    logic          ofifo_rd;
    logic          ififo_wr;
    logic          ififo_rd;
    logic          l0_rd;
    logic          l0_wr;
    logic          execute;
    logic          load;
  } inst_t;

  localparam inst_t INST_IDLE = inst_t'(34'h1_800C_0000);

  typedef enum logic [2:0] {
    S_IDLE, S_WLD, S_KLD, S_XLD, S_EXE, S_DRN, S_ACC, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;     // cycle / item count within the current state
  logic [AW-1:0] kij_q, kij_d;     // kernel position of the current pass
  logic [AW-1:0] k_q, k_d;         // accumulation: kernel position
  logic [AW-1:0] ki_q, ki_d;       // accumulation: kernel row
  logic [AW-1:0] kj_q, kj_d;       // accumulation: kernel column
  logic [AW-1:0] orow_q, orow_d;   // accumulation: output row
  logic [AW-1:0] ocol_q, ocol_d;   // accumulation: output column
  inst_t         inst_q, inst_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          clr;

  // Next-state, counter and instruction-word decode for the current state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kij_d   = kij_q;
    k_d     = k_q;
    ki_d    = ki_q;
    kj_d    = kj_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    inst_d  = INST_IDLE;
    clr     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          kij_d   = '0;
          clr     = 1'b1;
          state_d = S_WLD;
        end
      end

      S_WLD: begin
        // xmem read data lands one cycle later, so l0 is written one cycle behind the read
        if (cnt_q < COL_A) begin
          inst_d.cen_xmem = 1'b0;
          inst_d.a_xmem   = WB_A + kij_q * COL_A + cnt_q;
        end
        if (cnt_q != '0) inst_d.l0_wr = 1'b1;
        if (cnt_q == COL_A) begin
          clr     = 1'b1;
          state_d = S_KLD;
        end else begin
          cnt_d = cnt_q + ONE_A;
        end
      end

      S_KLD: begin
        if (cnt_q < COL_A) begin
          inst_d.l0_rd = 1'b1;
          inst_d.load  = 1'b1;
        end
        if (cnt_q == COL_A) begin
          clr     = 1'b1;
          state_d = S_XLD;
        end else begin
          cnt_d = cnt_q + ONE_A;
        end
      end

      S_XLD: begin
        if (cnt_q < NIJ_A) begin
          inst_d.cen_xmem = 1'b0;
          inst_d.a_xmem   = cnt_q;
        end
        if (cnt_q != '0) inst_d.l0_wr = 1'b1;
        if (cnt_q == NIJ_A) begin
          clr     = 1'b1;
          state_d = S_EXE;
        end else begin
          cnt_d = cnt_q + ONE_A;
        end
      end

      S_EXE: begin
        inst_d.l0_rd   = 1'b1;
        inst_d.execute = 1'b1;
        if (cnt_q == NIJ_M1) begin
          clr     = 1'b1;
          state_d = S_DRN;
        end else begin
          cnt_d = cnt_q + ONE_A;
        end
      end

      S_DRN: begin
        // One psum row moves from ofifo to pmem per valid cycle; invalid cycles just wait
        if (ofifo_valid) begin
          inst_d.ofifo_rd = 1'b1;
          inst_d.cen_pmem = 1'b0;
          inst_d.wen_pmem = 1'b0;
          inst_d.a_pmem   = kij_q * NIJ_A + cnt_q;
          if (cnt_q == NIJ_M1) begin
            clr = 1'b1;
            if (kij_q == KIJ_M1) begin
              state_d = S_ACC;
            end else begin
              kij_d   = kij_q + ONE_A;
              state_d = S_WLD;
            end
          end else begin
            cnt_d = cnt_q + ONE_A;
          end
        end
      end

      S_ACC: begin
        // Gather the len_kij partial sums of each output pixel; acc follows each read by a cycle
        if (cnt_q < NACC_A) begin
          inst_d.cen_pmem = 1'b0;
          inst_d.a_pmem   = k_q * NIJ_A + (orow_q + ki_q) * IW_A + ocol_q + kj_q;
          if (kj_q == KW_M1) begin
            kj_d = '0;
            ki_d = (ki_q == KW_M1) ? '0 : ki_q + ONE_A;
          end else begin
            kj_d = kj_q + ONE_A;
          end
          if (k_q == KIJ_M1) begin
            k_d = '0;
            if (ocol_q == OW_M1) begin
              ocol_d = '0;
              orow_d = orow_q + ONE_A;
            end else begin
              ocol_d = ocol_q + ONE_A;
            end
          end else begin
            k_d = k_q + ONE_A;
          end
        end
        if (cnt_q != '0) inst_d.acc = 1'b1;
        if (cnt_q == NACC_A) begin
          clr     = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + ONE_A;
        end
      end

      S_DONE: begin
        clr     = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        clr     = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    if (clr) begin
      cnt_d  = '0;
      k_d    = '0;
      ki_d   = '0;
      kj_d   = '0;
      orow_d = '0;
      ocol_d = '0;
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // State, counters and registered outputs; reset abandons any run in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      kij_q   <= '0;
      k_q     <= '0;
      ki_q    <= '0;
      kj_q    <= '0;
      orow_q  <= '0;
      ocol_q  <= '0;
      inst_q  <= INST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kij_q   <= kij_d;
      k_q     <= k_d;
      ki_q    <= ki_d;
      kj_q    <= kj_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      inst_q  <= inst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/core_ctrl.md
CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 Parameter col, default 8: PE columns and weight rows per kernel position.
REQ-002 Parameter len_kij, default 9: kernel positions (3x3).
REQ-003 Parameter len_nij, default 36: input pixels (6x6).
REQ-004 Parameter len_onij, default 16: output pixels (4x4).
REQ-005 Parameter iw, default 6: input row width. Parameter ow, default 4: output row width.
REQ-006 Parameter w_base, default 36: xmem base address of the weights.
REQ-007 clk  input  1  sole clock; all state updates on rising edge.
REQ-008 reset  input  1  asynchronous, active-low (0 = reset asserted).
REQ-009 start  input  1  one-cycle request to run one full convolution.
REQ-010 ofifo_valid  input  1  core ofifo holds a readable row.
REQ-011 inst  output  34  registered core instruction word.
- Bit fields: [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
REQ-012 busy  output  1  high from the cycle after start is accepted until DONE.
REQ-013 done  output  1  one-cycle pulse on completion.

Function
REQ-014 Idle inst value: CEN/WEN bits = 1, all other bits = 0, i.e. 34'h1_800C_0000.
- Every state drives the idle value on all fields not listed for that state.
REQ-015 States: IDLE, WLD, KLD, XLD, EXE, DRN, ACC, DONE; kij counter 0..len_kij-1.
REQ-016 IDLE: on start=1, clear kij and go to WLD. start in any other state is ignored.
REQ-017 WLD, col+1 cycles, cycle c:
- c<col: CEN_xmem=0, WEN_xmem=1, A_xmem=w_base+kij*col+c.
- c>=1: l0_wr=1 (data arrives one cycle after the read).
REQ-018 KLD, col+1 cycles: l0_rd=1 and load=1 for the first col cycles, then one idle gap cycle.
REQ-019 XLD, len_nij+1 cycles: same pattern as WLD with A_xmem=c (activations at xmem 0..len_nij-1).
REQ-020 EXE, len_nij cycles: l0_rd=1, execute=1.
REQ-021 DRN:
- Each cycle with ofifo_valid=1: ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=kij*len_nij+n, then n increments.
- Cycles with ofifo_valid=0: idle value, FSM waits indefinitely.
- Exit after n reaches len_nij. If kij<len_kij-1: increment kij, go to WLD. Otherwise go to ACC.
REQ-022 ACC: loop over o=0..len_onij-1 (orow=o/ow, ocol=o%ow) and inner k=0..len_kij-1 (ki=k/3, kj=k%3).
- Read pmem: CEN_pmem=0, WEN_pmem=1, A_pmem=k*len_nij+(orow+ki)*iw+ocol+kj.
- acc=1 exactly one cycle after each read.
- Duration len_onij*len_kij+1 cycles; last cycle carries only the final acc.
REQ-023 DONE: one cycle with done=1, busy=0, then IDLE.
REQ-024 Address arithmetic is unsigned 11-bit; maximum A_pmem 8*36+35=323, so no wrap occurs at default parameters.
REQ-025 All counters reset to 0 on every state entry.

Reset
REQ-026 When reset=0, immediately (asynchronously): state=IDLE, all counters=0, inst=34'h1_800C_0000, busy=0, done=0.
REQ-027 Reset mid-operation abandons the run; no partial pmem write or acc pulse follows release.
REQ-028 After release, the first start is accepted on the next rising edge.

Verification
REQ-029 Reset then idle:
- Hold reset=0 for 10 cycles -> inst=34'h1_800C_0000, busy=0.
- Release with no start -> inst unchanged for 20 cycles.
REQ-030 Start, first kernel position:
- start pulse -> WLD drives A_xmem=36..43 on 8 consecutive cycles, l0_wr high for 8 cycles lagging one cycle.
- Then load high for exactly 8 cycles.
REQ-031 Stalled drain:
- ofifo_valid toggled 1,0,1,... in DRN for kij=2 -> pmem writes only on valid cycles.
- A_pmem=72..107 in order; FSM leaves DRN after exactly 36 writes.
REQ-032 ACC addressing:
- o=5 -> reads at A_pmem 7,44,81,121,158,195,235,272,309.
- acc pulses trail each read by one cycle.
REQ-033 Full run with ofifo_valid tied 1:
- Exactly 9*36 pmem writes and 144 acc pulses.
- done pulses once; busy is high continuously from start+1 until done.
REQ-034 Reset mid-EXE at kij=4:
- Asynchronous return to the idle inst value.
- A new start restarts at kij=0, A_xmem=36.
